// File: rtl/distortion_core.sv
// distortion_core
//   Registered multi-channel distortion stage. Each accepted frame is scaled
//   by an unsigned fixed-point gain, shaped by the selected mode, and saturated
//   to the sample range. The result appears two edges after the frame is
//   accepted, behind a valid/ready handshake that supports back-pressure.
//
//   Pipeline:
//     s1  frame capture (samples, effective gain, mode, threshold)
//     s2  per-channel product p = x * g
//     out shift, waveshape and saturate; drives out_data / clip
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   input handshake (in_ready = pipeline enable)
//     in_data             NUM_CH packed signed samples, channel 0 in the LSBs
//     gain                unsigned gain, GAIN_FRAC fractional bits
//     threshold           unsigned clip level
//     mode                0 bypass, 1 hard clip, 2 half-wave, 3 full-wave,
//                         4 asymmetric clip, 5-7 bypass
//     out_valid/out_ready output handshake
//     out_data            NUM_CH packed signed results
//     clip                per-channel limiter indicator, aligned with out_data
//
//   Build option DISTORTION_GAIN_RAMP_EN: the effective gain is a register that
//   steps one LSB toward `gain` on every accepted frame. Without it, `gain` is
//   used directly.

module distortion_core #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [GAIN_W-1:0]        gain,
  input  logic [DATA_W-1:0]        threshold,
  input  logic [2:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        clip
);

  localparam int PW = DATA_W + GAIN_W + 1;
  localparam int BW = NUM_CH * DATA_W;

  localparam logic [2:0] MODE_HARD = 3'd1;
  localparam logic [2:0] MODE_HALF = 3'd2;
  localparam logic [2:0] MODE_FULL = 3'd3;
  localparam logic [2:0] MODE_ASYM = 3'd4;

  localparam logic [DATA_W-1:0]        THR_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     P_MAX   = PW'(S_MAX);
  localparam logic signed [PW-1:0]     P_MIN   = PW'(S_MIN);

  logic              out_valid_q;
  logic [BW-1:0]     out_data_q;
  logic [NUM_CH-1:0] clip_q;

  logic en;
  logic accept;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // ---------------------------------------------------------------- gain
  logic [GAIN_W-1:0] gain_frame;

`ifdef DISTORTION_GAIN_RAMP_EN
  logic [GAIN_W-1:0] gain_eff_q;
  logic [GAIN_W-1:0] gain_eff_d;

  always_comb begin
    gain_eff_d = gain_eff_q;
    if (gain_eff_q < gain)      gain_eff_d = gain_eff_q + 1'b1;
    else if (gain_eff_q > gain) gain_eff_d = gain_eff_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      gain_eff_q <= GAIN_W'(1 << GAIN_FRAC);
    else if (accept) gain_eff_q <= gain_eff_d;
  end

  // The frame uses the already-stepped value.
  assign gain_frame = gain_eff_d;
`else
  assign gain_frame = gain;
`endif

  // ---------------------------------------------------------------- stage 1
  logic              s1_valid_q;
  logic [BW-1:0]     s1_x_q;
  logic [GAIN_W-1:0] s1_gain_q;
  logic [2:0]        s1_mode_q;
  logic [DATA_W-1:0] s1_thr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_gain_q  <= '0;
      s1_mode_q  <= '0;
      s1_thr_q   <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_x_q    <= in_data;
        s1_gain_q <= gain_frame;
        s1_mode_q <= mode;
        s1_thr_q  <= threshold;
      end
    end
  end

  logic [NUM_CH*PW-1:0] prod_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_mul
    logic signed [DATA_W-1:0] x_w;
    assign x_w = s1_x_q[ch*DATA_W +: DATA_W];
    // Gain is zero-extended so the multiply stays signed.
    assign prod_d[ch*PW +: PW] = PW'(x_w) * PW'($signed({1'b0, s1_gain_q}));
  end

  // ---------------------------------------------------------------- stage 2
  logic                 s2_valid_q;
  logic [NUM_CH*PW-1:0] s2_p_q;
  logic [BW-1:0]        s2_x_q;
  logic [2:0]           s2_mode_q;
  logic [DATA_W-1:0]    s2_thr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_x_q     <= '0;
      s2_mode_q  <= '0;
      s2_thr_q   <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_p_q    <= prod_d;
        s2_x_q    <= s1_x_q;
        s2_mode_q <= s1_mode_q;
        s2_thr_q  <= s1_thr_q;
      end
    end
  end

  // Threshold is clamped to the largest positive sample so the limits are
  // always representable; asymmetric mode halves the negative limit.
  logic [DATA_W-1:0]   thr_eff;
  logic signed [PW-1:0] lim_hi;
  logic signed [PW-1:0] lim_lo;

  assign thr_eff = (s2_thr_q > THR_MAX) ? THR_MAX : s2_thr_q;
  assign lim_hi  = $signed(PW'(thr_eff));
  assign lim_lo  = (s2_mode_q == MODE_ASYM) ? -(lim_hi >>> 1) : -lim_hi;

  logic [BW-1:0]     res_d;
  logic [NUM_CH-1:0] clip_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_shape
    logic signed [PW-1:0]     y_w;
    logic signed [PW-1:0]     lim_w;
    logic signed [DATA_W-1:0] x_w;
    logic signed [DATA_W-1:0] r_w;
    logic                     c_w;

    assign x_w = s2_x_q[ch*DATA_W +: DATA_W];
    // Arithmetic shift floors toward minus infinity.
    assign y_w = $signed(s2_p_q[ch*PW +: PW]) >>> GAIN_FRAC;

    always_comb begin
      lim_w = y_w;
      r_w   = x_w;
      c_w   = 1'b0;
      case (s2_mode_q)
        MODE_HARD, MODE_ASYM: begin
          if (y_w > lim_hi) begin
            lim_w = lim_hi;
            c_w   = 1'b1;
          end else if (y_w < lim_lo) begin
            lim_w = lim_lo;
            c_w   = 1'b1;
          end
          if (lim_w > P_MAX) begin
            r_w = S_MAX;
            c_w = 1'b1;
          end else if (lim_w < P_MIN) begin
            r_w = S_MIN;
            c_w = 1'b1;
          end else begin
            r_w = lim_w[DATA_W-1:0];
          end
        end
        MODE_HALF: r_w = x_w[DATA_W-1] ? '0 : x_w;
        MODE_FULL: begin
          if (x_w == S_MIN)       r_w = S_MAX;
          else if (x_w[DATA_W-1]) r_w = -x_w;
        end
        default: r_w = x_w;
      endcase
    end

    assign res_d[ch*DATA_W +: DATA_W] = r_w;
    assign clip_d[ch]                 = c_w;
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      clip_q      <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= res_d;
        clip_q     <= clip_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign clip      = clip_q;

endmodule

// File: tb/tb_distortion_core.sv
module tb_distortion_core;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int GW = 8;
  localparam int GF = 4;
  localparam int W  = NC * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [GW-1:0] gain;
  logic [DW-1:0] threshold;
  logic [2:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [NC-1:0] clip;

  distortion_core #(.DATA_W(DW), .NUM_CH(NC), .GAIN_W(GW), .GAIN_FRAC(GF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .gain(gain), .threshold(threshold), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .clip(clip)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [W-1:0]  exp_d_q[$];
  logic [NC-1:0] exp_c_q[$];
  int            m_gain;

  // per-cycle observations
  logic          obs_v, obs_rdy;
  logic [W-1:0]  obs_d, exp_d;
  logic [NC-1:0] obs_c, exp_c;
  bit            acc_in, acc_out, got_out, stale;

  function automatic logic [W-1:0] pk(input int a, input int b);
    logic [W-1:0] r;
    r = {b[DW-1:0], a[DW-1:0]};
    return r;
  endfunction

  // Behavioural model: gain as a real ratio floored, then limiter rules.
  function automatic void ref_frame(input logic [W-1:0] x, input int g, input int md,
                                    input int thr, output logic [W-1:0] d,
                                    output logic [NC-1:0] c);
    longint xs, y, t, lo, r, maxv, minv;
    bit cl;
    maxv = (longint'(1) << (DW-1)) - 1;
    minv = -(longint'(1) << (DW-1));
    t = (thr > maxv) ? maxv : longint'(thr);
    d = '0;
    c = '0;
    for (int ch = 0; ch < NC; ch++) begin
      xs = longint'($signed(x[ch*DW +: DW]));
      y  = (xs * longint'(g)) >>> GF;
      cl = 1'b0;
      r  = xs;
      case (md)
        1, 4: begin
          lo = (md == 4) ? -(t / 2) : -t;
          if (y > t) begin r = t; cl = 1'b1; end
          else if (y < lo) begin r = lo; cl = 1'b1; end
          else r = y;
          if (r > maxv) begin r = maxv; cl = 1'b1; end
          if (r < minv) begin r = minv; cl = 1'b1; end
        end
        2: r = (xs < 0) ? 0 : xs;
        3: begin
          r = (xs < 0) ? -xs : xs;
          if (r > maxv) r = maxv;
        end
        default: r = xs;
      endcase
      d[ch*DW +: DW] = r[DW-1:0];
      c[ch] = cl;
    end
  endfunction

  task automatic flush_model;
    exp_d_q.delete();
    exp_c_q.delete();
    m_gain = 1 << GF;
  endtask

  // One clock: drive inputs, observe outputs, update the scoreboard.
  task automatic drive_cycle(input bit v, input logic [W-1:0] d, input int g,
                             input int thr, input int md, input bit ordy);
    logic [W-1:0]  ed;
    logic [NC-1:0] ec;
    int            eff;
    in_valid  = v;
    in_data   = d;
    gain      = GW'(g);
    threshold = DW'(thr);
    mode      = 3'(md);
    out_ready = ordy;
    #1;
    obs_v   = out_valid;
    obs_d   = out_data;
    obs_c   = clip;
    obs_rdy = in_ready;
    acc_in  = v && in_ready;
    acc_out = out_valid && out_ready;
    got_out = 1'b0;
    stale   = 1'b0;
    if (acc_in) begin
`ifdef DISTORTION_GAIN_RAMP_EN
      if (m_gain < g) m_gain++;
      else if (m_gain > g) m_gain--;
      eff = m_gain;
`else
      eff = g;
`endif
      ref_frame(d, eff, md, thr, ed, ec);
      exp_d_q.push_back(ed);
      exp_c_q.push_back(ec);
    end
    if (acc_out) begin
      got_out = 1'b1;
      if (exp_d_q.size() > 0) begin
        exp_d = exp_d_q.pop_front();
        exp_c = exp_c_q.pop_front();
      end else begin
        stale = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset;
    in_valid = 1'b0;
    rst_n = 1'b0;
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Walk the ramped gain to g with bypass frames (no-op without ramping).
  task automatic settle_gain(input int g);
`ifdef DISTORTION_GAIN_RAMP_EN
    int guard = 0;
    while ((m_gain != g || exp_d_q.size() > 0 || out_valid) && guard < 600) begin
      drive_cycle(m_gain != g, pk(100, -100), g, 20000, 0, 1'b1);
      if (got_out) begin
        compared++;
        if (stale || obs_d !== exp_d || obs_c !== exp_c) begin
          mismatched++;
          $display("FAIL settle_gain: got %h/%b want %h/%b", obs_d, obs_c, exp_d, exp_c);
        end
      end
      guard++;
    end
`endif
  endtask

  task automatic test_reset;
    #1;
    compared += 4;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_data !== '0)    begin mismatched++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    if (clip !== '0)        begin mismatched++; $display("FAIL reset_clip: got %b want 0", clip); end
    if (in_ready !== 1'b1)  begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int md[8]  = '{1, 1, 4, 4, 4, 2, 3, 3};
    int gn[8]  = '{32, 32, 32, 255, 32, 32, 32, 32};
    int th[8]  = '{20000, 20000, 20000, 40000, 0, 20000, 20000, 20000};
    int x0[8]  = '{8000, 15000, -15000, 32767, 5, -5, -5, -32768};
    int x1[8]  = '{-3000, -15000, 1000, 0, 0, 7, 7, 0};
    int e0[8]  = '{16000, 20000, -10000, 32767, 0, 0, 5, 32767};
    int e1[8]  = '{-6000, -20000, 2000, 0, 0, 7, 7, 0};
    logic [NC-1:0] ec[8] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    int k;
    bit got;
    for (int r = 0; r < 8; r++) begin
      settle_gain(gn[r]);
      drive_cycle(1'b1, pk(x0[r], x1[r]), gn[r], th[r], md[r], 1'b1);
      compared++;
      if (!acc_in) begin mismatched++; $display("FAIL dir_accept row %0d: in_ready %b want 1", r, obs_rdy); end
      k = 0;
      got = 1'b0;
      while (!got && k < 8) begin
        drive_cycle(1'b0, '0, gn[r], th[r], md[r], 1'b1);
        k++;
        if (got_out) begin
          got = 1'b1;
          compared += 2;
          if (stale || obs_d !== exp_d || obs_c !== exp_c) begin
            mismatched++;
            $display("FAIL dir_model row %0d: got %h/%b want %h/%b", r, obs_d, obs_c, exp_d, exp_c);
          end
          if (obs_d !== pk(e0[r], e1[r]) || obs_c !== ec[r]) begin
            mismatched++;
            $display("FAIL dir_const row %0d: got %h/%b want %h/%b", r, obs_d, obs_c, pk(e0[r], e1[r]), ec[r]);
          end
        end
      end
      // Output visible after the second edge following the accept edge.
      compared++;
      if (k != 3) begin mismatched++; $display("FAIL dir_latency row %0d: got %0d want 3", r, k); end
    end
  endtask

  task automatic test_backpressure(input int n);
    logic [W-1:0]  din, prev_d;
    logic [NC-1:0] prev_c;
    int g, thr, md, sent, rcv, guard;
    bit v, ordy, prev_stall;
    sent = 0; rcv = 0; guard = 0; prev_stall = 1'b0;
    prev_d = '0; prev_c = '0;
    din = $urandom; g = $urandom_range(0, 255); thr = $urandom_range(0, 65535); md = $urandom_range(0, 7);
    while ((sent < n || rcv < sent) && guard < 40 * n + 50) begin
      v    = (sent < n) && ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 1);
      drive_cycle(v, din, g, thr, md, ordy);
      compared++;
      if (obs_rdy !== (!obs_v || ordy)) begin
        mismatched++;
        $display("FAIL bp_in_ready: got %b want %b", obs_rdy, !obs_v || ordy);
      end
      if (prev_stall) begin
        compared++;
        if (obs_v !== 1'b1 || obs_d !== prev_d || obs_c !== prev_c) begin
          mismatched++;
          $display("FAIL bp_stall_hold: got %b %h/%b want 1 %h/%b", obs_v, obs_d, obs_c, prev_d, prev_c);
        end
      end
      prev_stall = obs_v && !ordy;
      prev_d = obs_d;
      prev_c = obs_c;
      if (acc_in) begin
        sent++;
        din = $urandom;
        if ($urandom_range(0, 5) == 0) din[DW-1:0] = 16'h8000;
        g = $urandom_range(0, 255); thr = $urandom_range(0, 65535); md = $urandom_range(0, 7);
      end
      if (got_out) begin
        rcv++;
        compared++;
        if (stale || obs_d !== exp_d || obs_c !== exp_c) begin
          mismatched++;
          $display("FAIL bp_data #%0d: got %h/%b want %h/%b", rcv, obs_d, obs_c, exp_d, exp_c);
        end
      end
      guard++;
    end
    compared++;
    if (rcv != n || exp_d_q.size() != 0) begin
      mismatched++;
      $display("FAIL bp_count: got %0d frames want %0d (pending %0d)", rcv, n, exp_d_q.size());
    end
  endtask

  task automatic test_mode_change;
    int md[5] = '{1, 1, 0, 0, 0};
    int e0[5] = '{20000, 20000, 12000, 12000, 12000};
    logic [NC-1:0] ec[5] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    int sent = 0, rcv = 0, guard = 0;
    settle_gain(32);
    while ((sent < 5 || rcv < 5) && guard < 40) begin
      drive_cycle(sent < 5, pk(12000, -12000), 32, 20000, (sent < 5) ? md[sent] : 0, 1'b1);
      if (acc_in) sent++;
      if (got_out) begin
        compared++;
        if (stale || rcv >= 5 || obs_d !== pk(e0[rcv], -e0[rcv]) || obs_c !== ec[rcv]) begin
          mismatched++;
          $display("FAIL mode_change #%0d: got %h/%b want %h/%b", rcv, obs_d, obs_c,
                   pk(e0[rcv % 5], -e0[rcv % 5]), ec[rcv % 5]);
        end
        rcv++;
      end
      guard++;
    end
    compared++;
    if (rcv != 5) begin mismatched++; $display("FAIL mode_change_count: got %0d want 5", rcv); end
  endtask

  task automatic test_reset_midstream;
    int sent = 0, rcv = 0, guard = 0;
    // fill the pipe while stalled
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, pk(1000 + i, -1000 - i), 32, 20000, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    compared += 3;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    if (out_data !== '0)    begin mismatched++; $display("FAIL rst_mid_data: got %h want 0", out_data); end
    if (clip !== '0)        begin mismatched++; $display("FAIL rst_mid_clip: got %b want 0", clip); end
    flush_model();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, '0, 32, 20000, 1, 1'b1);
      compared++;
      if (obs_v !== 1'b0) begin mismatched++; $display("FAIL rst_mid_stale: out_valid %b want 0", obs_v); end
    end
    while ((sent < 3 || rcv < 3) && guard < 40) begin
      drive_cycle(sent < 3, pk(200 * sent - 300, 50), 32, 20000, 1, 1'b1);
      if (acc_in) sent++;
      if (got_out) begin
        rcv++;
        compared++;
        if (stale || obs_d !== exp_d || obs_c !== exp_c) begin
          mismatched++;
          $display("FAIL rst_mid_post #%0d: got %h/%b want %h/%b", rcv, obs_d, obs_c, exp_d, exp_c);
        end
      end
      guard++;
    end
    compared++;
    if (rcv != 3) begin mismatched++; $display("FAIL rst_mid_count: got %0d want 3", rcv); end
  endtask

  task automatic test_gain_ramp;
`ifdef DISTORTION_GAIN_RAMP_EN
    int e[5] = '{1062, 1125, 1187, 1250, 1250};
`else
    int e[5] = '{1250, 1250, 1250, 1250, 1250};
`endif
    int sent = 0, rcv = 0, guard = 0;
    pulse_reset();
    while ((sent < 5 || rcv < 5) && guard < 40) begin
      drive_cycle(sent < 5, pk(1000, 1000), 20, 20000, 1, 1'b1);
      if (acc_in) sent++;
      if (got_out) begin
        compared += 2;
        if (stale || obs_d !== exp_d || obs_c !== exp_c) begin
          mismatched++;
          $display("FAIL ramp_model #%0d: got %h/%b want %h/%b", rcv, obs_d, obs_c, exp_d, exp_c);
        end
        if (rcv >= 5 || obs_d !== pk(e[rcv % 5], e[rcv % 5]) || obs_c !== 2'b00) begin
          mismatched++;
          $display("FAIL ramp_const #%0d: got %h/%b want %h/00", rcv, obs_d, obs_c, pk(e[rcv % 5], e[rcv % 5]));
        end
        rcv++;
      end
      guard++;
    end
    compared++;
    if (rcv != 5) begin mismatched++; $display("FAIL ramp_count: got %0d want 5", rcv); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; gain = '0; threshold = '0; mode = '0; out_ready = 1'b0;
    flush_model();
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure(10);
    test_mode_change();
    test_reset_midstream();
    test_backpressure(150);
    test_gain_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/distortion_core.md
# distortion_core

Parametrised, clocked, multi-channel distortion stage for the audio effects chain. Accepts one frame (all channels) per valid/ready handshake, applies fixed-point gain and one of several waveshaping modes, and presents the result two cycles later on a matching output handshake. Sits between the codec deserialiser and the downstream effect blocks. It replaces the combinational stereo distortion with registered, back-pressurable, width- and channel-generic operation plus per-channel clip reporting.

## Interface
- `DATA_W`, default 16: signed sample width.
- `NUM_CH`, default 2: channels per frame; channel 0 occupies the LSBs of packed buses.
- `GAIN_W`, default 8: unsigned gain width.
- `GAIN_FRAC`, default 4: fractional bits of gain (gain = `gain`/2^GAIN_FRAC).

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input frame valid.
- `in_ready`  out  1  block can accept a frame this cycle.
- `in_data`  in  NUM_CH*DATA_W  packed signed samples.
- `gain`  in  GAIN_W  unsigned gain.
- `threshold`  in  DATA_W  unsigned clip level.
- `mode`  in  3  0 bypass, 1 hard clip, 2 half-wave rectify, 3 full-wave rectify, 4 asymmetric clip, 5–7 bypass.
- `out_valid`  out  1  output frame valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  NUM_CH*DATA_W  packed signed results.
- `clip`  out  NUM_CH  per-channel clip indicator, aligned with `out_data`.

## Operation
- Transfer occurs on a rising edge with valid && ready, on either side.
- `mode`, `threshold` and effective gain are captured with the frame in stage 1. Changes never affect frames already in flight.
- Stage 1 computes per channel `p = x * g` as a signed product of DATA_W+GAIN_W+1 bits, with g zero-extended.
- Stage 2 computes `y = p >>> GAIN_FRAC`, an arithmetic shift that floors. It then applies the mode and saturates to the DATA_W signed range.
- Let T = min(threshold, 2^(DATA_W-1)-1).
- Mode 1: y > T gives T; y < -T gives -T; otherwise y. `clip` is set when limiting occurred.
- Mode 4: the positive limit is T and the negative limit is -(T>>1). `clip` is as in mode 1.
- Mode 2: output is x if x ≥ 0, else 0. Gain is not applied.
- Mode 3: output is |x|. -2^(DATA_W-1) maps to 2^(DATA_W-1)-1. Gain is not applied.
- Bypass modes: output is x and `clip` = 0.
- In modes 1 and 4, a value still outside the DATA_W range after limiting is saturated, and `clip` is set.
- In modes 1 and 4, threshold = 0 gives an output of 0, and `clip` is set for any nonzero y.

## Timing
- Reset (asynchronous assert) values:
  - `out_valid` = 0, `out_data` = 0, `clip` = 0.
  - All stage valids = 0.
  - Ramp gain = 1<<GAIN_FRAC.
- Deassertion of `rst_n` is synchronised externally.
- Pipeline enable: en = !out_valid || out_ready. `in_ready` = en, which is combinational from `out_ready`.
- Latency: a frame accepted at edge N appears on `out_valid` / `out_data` after edge N+2 when not stalled.
- Throughput: one frame per cycle.
- Stall: while out_valid && !out_ready, all stages hold and `out_data` / `clip` stay stable. The block never drops or duplicates a frame.
- Bubbles propagate as invalid stages. `out_valid` falls after an accepted output if no frame follows.
- Reset mid-stream flushes all in-flight frames. The first post-reset accept is the next frame seen.

## Configuration
- `DISTORTION_GAIN_RAMP_EN` defined:
  - A registered effective gain steps 1 LSB toward `gain` on each accepted frame; the stepped value is the gain used for that frame.
  - This removes zipper noise on gain changes.
- Undefined: `gain` is sampled directly with each frame.

## Test plan
Parameters are defaults, with gain 32 (2.0) and threshold 20000 unless stated.
- Mode 1, in 8000 / -3000 → out 16000 / -6000 two cycles later, clip 00. In 15000 / -15000 → 20000 / -20000, clip 11.
- Mode 4, in -15000 → -10000, clip 1. Gain 255 and threshold 40000, in 32767 → 32767, clip 1. Threshold 0, in 5 → 0, clip 1.
- Modes 2 and 3, in -5 / 7 → mode 2 gives 0 / 7; mode 3 gives 5 / 7. Mode 3 with in -32768 → 32767.
- Backpressure: stream 10 frames with out_ready toggling pseudo-randomly → all 10 outputs arrive in order, values stable while stalled, in_ready tracks en.
- Mode change from 1 to 0 with 2 frames in flight → those frames are processed in mode 1, later frames are bypassed. Assert rst_n = 0 mid-stream → out_valid = 0 immediately, then no stale frames appear.
- `DISTORTION_GAIN_RAMP_EN` defined, gain step from 16 to 20 → frames use gains 17, 18, 19, 20, 20. In 1000 → 1062, 1125, 1187, 1250, 1250.
